// File: rtl/vga_sp_pkg.sv
// Shared superpixel / VGA RAM geometry and the
// reader FSM encoding.
package vga_sp_pkg;

  localparam int SPIXEL_X_WIDTH = 6;
  localparam int SPIXEL_Y_WIDTH = 6;
  localparam int SPIXEL_X_MAX   = 63;
  localparam int SPIXEL_Y_MAX   = 47;
  localparam int SPIXEL_SIZE    = 10;
  localparam int PIXEL_X_RES    = 640;
  localparam int VGA_ADDR_WIDTH = 19;
  localparam int COLOR_ID_WIDTH = 8;

  typedef logic [SPIXEL_X_WIDTH-1:0] spx_t;
  typedef logic [SPIXEL_Y_WIDTH-1:0] spy_t;
  typedef logic [VGA_ADDR_WIDTH-1:0] addr_t;
  typedef logic [COLOR_ID_WIDTH-1:0] color_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } rd_state_t;

  function automatic spx_t clamp_x(input spx_t v);
    if (int'(v) > SPIXEL_X_MAX)
      return spx_t'(SPIXEL_X_MAX);
    return v;
  endfunction

  function automatic spy_t clamp_y(input spy_t v);
    if (int'(v) > SPIXEL_Y_MAX)
      return spy_t'(SPIXEL_Y_MAX);
    return v;
  endfunction

endpackage

// File: rtl/read_rectangle_sp_if.sv
// Request, output stream and RAM read port of
// the superpixel rectangle reader.
interface read_rectangle_sp_if;

  vga_sp_pkg::spx_t   x0;
  vga_sp_pkg::spy_t   y0;
  vga_sp_pkg::spx_t   x1;
  vga_sp_pkg::spy_t   y1;
  logic               istart;
  logic               obusy;
  vga_sp_pkg::color_t odata;
  logic               odata_vld;
  logic               iready;
  logic               olast;
  logic               odone;
  vga_sp_pkg::addr_t  oaddr;
  logic               ord;
  vga_sp_pkg::color_t irdata;

  modport slave (
    input  x0, y0, x1, y1, istart,
    input  iready, irdata,
    output obusy, odata, odata_vld,
    output olast, odone, oaddr, ord
  );

  modport master (
    output x0, y0, x1, y1, istart,
    output iready, irdata,
    input  obusy, odata, odata_vld,
    input  olast, odone, oaddr, ord
  );

endinterface

// File: rtl/spixel2addr.sv
// Superpixel (cx,cy) to linear VGA RAM address
// of its top-left physical pixel.
module spixel2addr
  import vga_sp_pkg::*;
(
  input  spx_t  i_cx,
  input  spy_t  i_cy,
  output addr_t o_addr
);

  addr_t w_cx;
  addr_t w_cy;
  addr_t w_px;
  addr_t w_py;

  assign w_cx = addr_t'(i_cx);
  assign w_cy = addr_t'(i_cy);

  // x10 as x8 + x2, x640 as x512 + x128
  assign w_px = (w_cx << 3) + (w_cx << 1);
  assign w_py = (w_cy << 3) + (w_cy << 1);

  assign o_addr = (w_py << 9) + (w_py << 7) + w_px;

endmodule

// File: rtl/read_rectangle_sp.sv
// Walks a superpixel rectangle in raster order and
// streams one RAM sample per superpixel.
module read_rectangle_sp
  import vga_sp_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  read_rectangle_sp_if.slave bus
);

  localparam logic [1:0] LAT_M1 =
    2'(RD_LATENCY - 1);

  rd_state_t r_state;
  rd_state_t w_state;
  spx_t      r_xs, r_xe, r_cx;
  spx_t      w_xs, w_xe, w_cx;
  spy_t      r_ys, r_ye, r_cy;
  spy_t      w_ys, w_ye, w_cy;
  logic [1:0] r_wcnt, w_wcnt;
  color_t    r_data, w_data;

  spx_t  w_x0c, w_x1c;
  spy_t  w_y0c, w_y1c;
  logic  w_last;
  logic  w_vld;
  logic  w_ord;
  addr_t w_addr;

  assign w_x0c = clamp_x(bus.x0);
  assign w_x1c = clamp_x(bus.x1);
  assign w_y0c = clamp_y(bus.y0);
  assign w_y1c = clamp_y(bus.y1);

  assign w_last = (r_cx == r_xe) &&
                  (r_cy == r_ye);

  spixel2addr u_addr (
    .i_cx   (r_cx),
    .i_cy   (r_cy),
    .o_addr (w_addr)
  );

  // state, cursor, corners and sample registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_xs    <= '0;
      r_xe    <= '0;
      r_ys    <= '0;
      r_ye    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_wcnt  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state;
      r_xs    <= w_xs;
      r_xe    <= w_xe;
      r_ys    <= w_ys;
      r_ye    <= w_ye;
      r_cx    <= w_cx;
      r_cy    <= w_cy;
      r_wcnt  <= w_wcnt;
      r_data  <= w_data;
    end
  end

  // next state and raster walk
  always_comb begin
    w_state = r_state;
    w_xs    = r_xs;
    w_xe    = r_xe;
    w_ys    = r_ys;
    w_ye    = r_ye;
    w_cx    = r_cx;
    w_cy    = r_cy;
    w_wcnt  = r_wcnt;
    w_data  = r_data;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.istart) begin
          w_xs = (w_x0c < w_x1c) ? w_x0c : w_x1c;
          w_xe = (w_x0c < w_x1c) ? w_x1c : w_x0c;
          w_ys = (w_y0c < w_y1c) ? w_y0c : w_y1c;
          w_ye = (w_y0c < w_y1c) ? w_y1c : w_y0c;
          w_cx = w_xs;
          w_cy = w_ys;
          w_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_wcnt  = '0;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wcnt == LAT_M1) begin
          w_data  = bus.irdata;
          w_state = ST_OUT;
        end else begin
          w_wcnt = r_wcnt + 2'd1;
        end
      end
      ST_OUT: begin
        if (bus.iready) begin
          if (w_last) begin
            w_state = ST_DONE;
          end else begin
            if (r_cx == r_xe) begin
              w_cx = r_xs;
              w_cy = r_cy + spy_t'(1);
            end else begin
              w_cx = r_cx + spx_t'(1);
            end
            w_state = ST_ISSUE;
          end
        end
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
  end

  // outputs decoded from the registered state
  always_comb begin
    w_vld = (r_state == ST_OUT);
    w_ord = (r_state == ST_ISSUE);
    bus.ord       = w_ord;
    bus.oaddr     = w_ord ? w_addr : '0;
    bus.odata_vld = w_vld;
    bus.odata     = w_vld ? r_data : '0;
    bus.olast     = w_vld & w_last;
    bus.odone     = (r_state == ST_DONE);
    bus.obusy     = (r_state == ST_ISSUE) ||
                    (r_state == ST_WAIT)  ||
                    (r_state == ST_OUT);
  end

endmodule

// File: doc/read_rectangle_sp.md
Name: read_rectangle_sp

Overview:
Reader counterpart of the superpixel rectangle drawer. It walks a superpixel rectangle in raster order and reads one sample per superpixel from VGA RAM, taken at the superpixel's top-left physical pixel. Each sample is returned as a colour ID on a valid/ready stream. It sits beside the drawer on the VGA RAM read port and serves readback, collision checks and screen capture.

Parameters:
SPIXEL_X_WIDTH, 6, superpixel X coordinate width
SPIXEL_Y_WIDTH, 6, superpixel Y coordinate width
SPIXEL_X_MAX, 63, largest legal superpixel X
SPIXEL_Y_MAX, 47, largest legal superpixel Y
SPIXEL_SIZE, 10, physical pixels per superpixel edge
PIXEL_X_RES, 640, physical line length used for address generation
VGA_ADDR_WIDTH, 19, RAM address width
COLOR_ID_WIDTH, 8, colour ID width
RD_LATENCY, 1, RAM read latency in cycles (1 to 3)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
x0  in  SPIXEL_X_WIDTH  corner A, X
y0  in  SPIXEL_Y_WIDTH  corner A, Y
x1  in  SPIXEL_X_WIDTH  corner B, X
y1  in  SPIXEL_Y_WIDTH  corner B, Y
istart  in  1  request; accepted only when obusy=0
obusy  out  1  high from the cycle after acceptance until odone
odata  out  COLOR_ID_WIDTH  sampled colour ID
odata_vld  out  1  odata valid
iready  in  1  consumer ready; a beat transfers when odata_vld and iready are both high
olast  out  1  high with the final beat
odone  out  1  one-cycle pulse after the final beat transfers
oaddr  out  VGA_ADDR_WIDTH  RAM read address; 0 when ord=0
ord  out  1  RAM read strobe
irdata  in  COLOR_ID_WIDTH  RAM read data, valid RD_LATENCY cycles after ord

Behaviour:
- Reset (async): state IDLE. All outputs 0, all counters 0, latched corners 0.
- Acceptance:
  - On istart while in IDLE, latch xs=min(x0,x1), xe=max(x0,x1), ys=min(y0,y1), ye=max(y0,y1).
  - Each coordinate is clamped to SPIXEL_*_MAX before min/max.
  - Set cx=xs, cy=ys; next state ISSUE.
  - istart in any other state is ignored, with no queueing.
- FSM states: IDLE, ISSUE, WAIT, OUT, DONE.
  - ISSUE: ord=1 and oaddr=addr(cx,cy) for exactly one cycle. Go to WAIT.
  - WAIT: count RD_LATENCY cycles. In the cycle irdata is valid, capture it into the data register and go to OUT. No combinational path from irdata to odata.
  - OUT: odata_vld=1. odata holds stable until transfer. olast=(cx==xe && cy==ye).
  - On transfer, not last: cx==xe → cx=xs, cy=cy+1; otherwise cx=cx+1. Go to ISSUE.
  - On transfer, last: go to DONE.
  - DONE: odone=1 for one cycle, obusy=0. Go to IDLE.
- An istart asserted during DONE is ignored; requesters wait for IDLE.
- Address: addr = (cy*SPIXEL_SIZE)*PIXEL_X_RES + cx*SPIXEL_SIZE, computed in VGA_ADDR_WIDTH bits with no truncation for legal coordinates. Max is 470*640+630=301430.
- Beat count = (xe-xs+1)*(ye-ys+1). Minimum 1 (x0==x1, y0==y1); maximum 3072.
- Latency from istart to first odata_vld = 2+RD_LATENCY cycles. Per-beat period = 2+RD_LATENCY cycles when iready is held high.
- iready low in OUT stalls indefinitely; no RAM reads are issued while stalled.
- rst mid-operation aborts at once. No odone. The partially read stream is discarded.
- odata and olast are 0 whenever odata_vld=0.

Decomposition:
- Shared package vga_sp_pkg: superpixel/pixel widths and maxima, SPIXEL_SIZE, PIXEL_X_RES, VGA_ADDR_WIDTH, COLOR_ID_WIDTH, and the FSM state encoding.
- One sub-module, spixel2addr: combinational superpixel (cx,cy) to RAM address, implemented with shift-add (*10 = <<3 + <<1, *640 = <<9 + <<7).
- The drawer reuses this sub-module.

Test Plan:
- Single superpixel, x0=x1=5, y0=y1=3, RAM[19250]=0x2A, iready=1 → ord once at oaddr=19250; one beat odata=0x2A with olast=1; odone one cycle later.
- Swapped corners (2,1)/(0,0), RAM pre-filled with distinct IDs → 6 beats. Addresses in order: 0, 10, 20, 6400, 6410, 6420. olast on the 6th beat only.
- Backpressure on a 3x1 rectangle, iready low for 5 cycles on beat 2 → odata stable, no ord during the stall, exactly 3 beats total.
- Clamp: x1=63 with y0=0, y1=0, and x0=y0=0 with y1=60 → y is clamped to 47, giving last beat address 470*640=300800.
- Reset mid-stream: assert rst after 4 beats of a 4x4 rectangle → all outputs 0 immediately, no odone. A new istart then completes normally.
- istart pulsed while obusy=1 → ignored; beat count is unchanged. Repeat with RD_LATENCY=3 and check a beat period of 5 cycles.
